usb_fs_in_rr_arb: RTL and testbench
===================================

Name: usb_fs_in_rr_arb

Overview:
- Round-robin, transaction-locked arbiter that shares the single IN data path of the USB full-speed protocol engine among NUM_IN_EPS IN endpoints.
- Grants are registered and held for a whole IN transaction, released on protocol-engine completion or requester withdrawal.
- The priority pointer advances past the last owner so no endpoint starves.
- Sits between the IN endpoint blocks and the protocol engine's transmit path.

Parameters:
- NUM_IN_EPS, 4, number of IN endpoints (1..16).
- IDX_W, $clog2(NUM_IN_EPS) with minimum 1, width of the owner index.
- TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_ep_req  input  NUM_IN_EPS  per-endpoint request, level; endpoint i has packet data pending.
- in_ep_grant  output  NUM_IN_EPS  registered one-hot (or zero) grant.
- in_ep_data  input  NUM_IN_EPS*8  endpoint i byte on bits [i*8 +: 8].
- pe_in_done  input  1  one-cycle pulse from protocol engine; current IN transaction finished (ACK, NAK or timeout).
- arb_in_ep_data  output  8  byte of the granted endpoint; 0 when no grant.
- arb_valid  output  1  high while a grant is held.
- arb_owner  output  IDX_W  index of granted endpoint; 0 when idle.
- arb_timeout  output  1  one-cycle pulse on watchdog release; tied 0 without the feature.

Behaviour:
- Reset (async, active-high) values: in_ep_grant=0, arb_valid=0, arb_owner=0, arb_timeout=0, rr_ptr=0, state=IDLE. Reset mid-transaction drops the grant immediately.
- State IDLE:
  - If in_ep_req != 0, select the first set request scanning from rr_ptr upward, modulo NUM_IN_EPS.
  - On the next edge: in_ep_grant[sel]=1, arb_owner=sel, arb_valid=1, state→LOCKED.
  - Latency is 1 cycle from request sampled to grant visible.
- State LOCKED:
  - Grant is held regardless of other requests.
  - Release conditions: pe_in_done=1, or in_ep_req[arb_owner]=0 (withdrawal), or the watchdog fires.
  - On release, at the next edge: grant=0, arb_valid=0, arb_owner=0, rr_ptr=(owner+1) mod NUM_IN_EPS, state→IDLE.
  - Release always inserts at least one idle cycle before the next grant, including when pe_in_done and other requests coincide.
- Data mux: arb_in_ep_data is combinational from in_ep_data of arb_owner, gated by arb_valid; it is 0 when idle.
- Invariants: $onehot0(in_ep_grant) always holds; arb_valid equals |in_ep_grant.
- pe_in_done while IDLE is ignored; rr_ptr is unchanged.
- NUM_IN_EPS=1: rr_ptr stays 0; behaviour reduces to a locked single grant.
- rr_ptr wrap: owner NUM_IN_EPS-1 → rr_ptr=0.

Optional Feature:
- Macro: USB_FS_IN_ARB_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering LOCKED and increments each LOCKED cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no other release, the grant releases as above and arb_timeout pulses 1 on the same edge that clears the grant.
  - pe_in_done or withdrawal in that same cycle takes precedence; no timeout pulse is issued.
- When undefined: no counter, arb_timeout tied 0, grant held indefinitely until done or withdrawal.

Test Plan:
- Reset while EP2 granted -> in_ep_grant=0000, arb_valid=0, arb_in_ep_data=0 asynchronously; after deassert with req=0100, grant=0100 one cycle later.
- req=1111 held, pe_in_done pulsed 3 cycles after each grant -> grant sequence 0001,0010,0100,1000,0001 with one idle cycle between each.
- EP1 granted, in_ep_data[15:8]=8'hA5, other lanes 8'h00 -> arb_in_ep_data=8'hA5, arb_owner=1; after done -> 8'h00.
- EP3 granted, req drops to 0000 without done -> grant clears next edge, rr_ptr=0; new req=0001 -> grant 0001.
- pe_in_done pulsed while idle, then req=0110 with rr_ptr=2 -> grant 0100 (rr_ptr unchanged).
- With USB_FS_IN_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, EP0 held without done -> arb_timeout pulses 8 cycles after grant, grant clears, next grant to EP1 if requesting.

Source files
------------

// File: rtl/usb_fs_in_rr_arb.sv
// usb_fs_in_rr_arb: round-robin, transaction-locked arbiter for the FS IN data path.
// Optional watchdog release is enabled by defining USB_FS_IN_ARB_TIMEOUT_EN.
module usb_fs_in_rr_arb #(
    parameter int NUM_IN_EPS     = 4,
    parameter int IDX_W          = (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN_EPS-1:0]   in_ep_req,
    output logic [NUM_IN_EPS-1:0]   in_ep_grant,
    input  logic [NUM_IN_EPS*8-1:0] in_ep_data,
    input  logic                    pe_in_done,
    output logic [7:0]              arb_in_ep_data,
    output logic                    arb_valid,
    output logic [IDX_W-1:0]        arb_owner,
    output logic                    arb_timeout
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [IDX_W:0]   NUM_W = (IDX_W+1)'(NUM_IN_EPS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_IN_EPS - 1);

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]        owner_nxt, ptr_inc;
    logic [NUM_IN_EPS-1:0]   grant_nxt;
    logic                    valid_nxt;
    logic [2*NUM_IN_EPS-1:0] req_dbl;
    logic [NUM_IN_EPS-1:0]   req_rot;
    logic [IDX_W-1:0]        sel_ofs, sel;
    logic [IDX_W:0]          sel_sum;
    logic                    sel_found;
    logic                    withdrawn, wd_fire, release_now;

    // Rotate requests so bit 0 is the endpoint at rr_ptr, then take the lowest set bit.
    assign req_dbl = {in_ep_req, in_ep_req} >> rr_ptr;
    assign req_rot = req_dbl[NUM_IN_EPS-1:0];

    always_comb begin
        sel_ofs   = '0;
        sel_found = 1'b0;
        for (int k = NUM_IN_EPS - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sel_ofs   = IDX_W'(k);
                sel_found = 1'b1;
            end
        end
    end

    assign sel_sum = {1'b0, rr_ptr} + {1'b0, sel_ofs};
    assign sel     = (sel_sum >= NUM_W) ? IDX_W'(sel_sum - NUM_W)
                                        : sel_sum[IDX_W-1:0];

    assign ptr_inc     = (arb_owner == LAST) ? '0 : arb_owner + IDX_W'(1);
    assign withdrawn   = ~|(in_ep_req & in_ep_grant);
    assign release_now = pe_in_done | withdrawn | wd_fire;

`ifdef USB_FS_IN_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            arb_timeout <= 1'b0;
        end else begin
            wd_cnt      <= (state == LOCKED) ? wd_cnt + CNT_W'(1) : '0;
            arb_timeout <= wd_fire & ~pe_in_done & ~withdrawn;
        end
    end

    assign wd_fire = (state == LOCKED) && (wd_cnt == WD_LIMIT);
`else
    assign wd_fire     = 1'b0;
    assign arb_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        grant_nxt  = in_ep_grant;
        owner_nxt  = arb_owner;
        valid_nxt  = arb_valid;
        rr_ptr_nxt = rr_ptr;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nxt = LOCKED;
                    grant_nxt = NUM_IN_EPS'(1) << sel;
                    owner_nxt = sel;
                    valid_nxt = 1'b1;
                end
            end
            LOCKED: begin
                // Release always lands in IDLE, forcing one idle cycle before the next grant.
                if (release_now) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    owner_nxt  = '0;
                    valid_nxt  = 1'b0;
                    rr_ptr_nxt = ptr_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            in_ep_grant <= '0;
            arb_owner   <= '0;
            arb_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            in_ep_grant <= grant_nxt;
            arb_owner   <= owner_nxt;
            arb_valid   <= valid_nxt;
        end
    end

    always_comb begin
        arb_in_ep_data = '0;
        for (int i = 0; i < NUM_IN_EPS; i++) begin
            if (in_ep_grant[i]) arb_in_ep_data = in_ep_data[i*8 +: 8];
        end
    end

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// tb_usb_fs_in_rr_arb: vector table, reset sequence and randomized run
// against a behavioural round-robin model.
module tb_usb_fs_in_rr_arb;

    localparam int N  = 4;
    localparam int TO = 8;
`ifdef USB_FS_IN_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  in_ep_req;
    logic [N-1:0]  in_ep_grant;
    logic [N*8-1:0] in_ep_data;
    logic          pe_in_done;
    logic [7:0]    arb_in_ep_data;
    logic          arb_valid;
    logic [1:0]    arb_owner;
    logic          arb_timeout;

    int n_pass  = 0;
    int n_total = 0;

    // Model: owner is -1 when idle; age counts locked cycles since grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_age   = 0;
    bit m_to    = 1'b0;

    usb_fs_in_rr_arb #(
        .NUM_IN_EPS(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_ep_req(in_ep_req),
        .in_ep_grant(in_ep_grant),
        .in_ep_data(in_ep_data),
        .pe_in_done(pe_in_done),
        .arb_in_ep_data(arb_in_ep_data),
        .arb_valid(arb_valid),
        .arb_owner(arb_owner),
        .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit rq(input logic [N-1:0] r, input int i);
        logic [N-1:0] s;
        s = r >> i;
        return s[0];
    endfunction

    function automatic logic [7:0] lane(input logic [N*8-1:0] d, input int i);
        logic [N*8-1:0] s;
        s = d >> (8 * i);
        return s[7:0];
    endfunction

    task automatic check_model();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (4'b0001 << m_owner);
        chk("grant", 32'(in_ep_grant), 32'(eg));
        chk("valid", 32'(arb_valid), 32'(m_owner >= 0));
        chk("owner", 32'(arb_owner), (m_owner < 0) ? 0 : m_owner);
        chk("data", 32'(arb_in_ep_data),
            (m_owner < 0) ? 32'd0 : 32'(lane(in_ep_data, m_owner)));
        chk("timeout", 32'(arb_timeout), 32'(m_to));
        chk("onehot0", 32'($onehot0(in_ep_grant)), 32'd1);
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic done, input logic [N*8-1:0] data);
        int no, np, na;
        bit nt;
        in_ep_req  = req;
        pe_in_done = done;
        in_ep_data = data;
        no = m_owner; np = m_ptr; na = m_age + 1; nt = 1'b0;
        if (m_owner < 0) begin
            na = 0;
            for (int k = 0; k < N; k++) begin
                if (rq(req, (m_ptr + k) % N)) begin
                    no = (m_ptr + k) % N;
                    break;
                end
            end
        end else if (done || !rq(req, m_owner) || (TO_EN && m_age == TO - 1)) begin
            nt = !done && rq(req, m_owner);
            np = (m_owner + 1) % N;
            no = -1;
        end
        @(posedge clk);
        #1;
        m_owner = no; m_ptr = np; m_age = na; m_to = nt;
        check_model();
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] g;
        logic [1:0]   own;
        logic [7:0]   d;
    } vec_t;

    vec_t tbl[30];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb timeout");
    end

    initial begin
        logic [N-1:0]   r;
        logic [N*8-1:0] dat;

        tbl[0]  = '{4'hF, 1'b0, 4'h1, 2'd0, 8'h00};
        tbl[1]  = '{4'hF, 1'b0, 4'h1, 2'd0, 8'h00};
        tbl[2]  = '{4'hF, 1'b0, 4'h1, 2'd0, 8'h00};
        tbl[3]  = '{4'hF, 1'b1, 4'h0, 2'd0, 8'h00};
        tbl[4]  = '{4'hF, 1'b0, 4'h2, 2'd1, 8'hA5};
        tbl[5]  = '{4'hF, 1'b0, 4'h2, 2'd1, 8'hA5};
        tbl[6]  = '{4'hF, 1'b0, 4'h2, 2'd1, 8'hA5};
        tbl[7]  = '{4'hF, 1'b1, 4'h0, 2'd0, 8'h00};
        tbl[8]  = '{4'hF, 1'b0, 4'h4, 2'd2, 8'h00};
        tbl[9]  = '{4'hF, 1'b0, 4'h4, 2'd2, 8'h00};
        tbl[10] = '{4'hF, 1'b0, 4'h4, 2'd2, 8'h00};
        tbl[11] = '{4'hF, 1'b1, 4'h0, 2'd0, 8'h00};
        tbl[12] = '{4'hF, 1'b0, 4'h8, 2'd3, 8'h00};
        tbl[13] = '{4'hF, 1'b0, 4'h8, 2'd3, 8'h00};
        tbl[14] = '{4'hF, 1'b0, 4'h8, 2'd3, 8'h00};
        tbl[15] = '{4'hF, 1'b1, 4'h0, 2'd0, 8'h00};
        tbl[16] = '{4'hF, 1'b0, 4'h1, 2'd0, 8'h00};
        tbl[17] = '{4'hF, 1'b1, 4'h0, 2'd0, 8'h00};
        tbl[18] = '{4'h2, 1'b0, 4'h2, 2'd1, 8'hA5};
        tbl[19] = '{4'h0, 1'b0, 4'h0, 2'd0, 8'h00};
        tbl[20] = '{4'h0, 1'b1, 4'h0, 2'd0, 8'h00};
        tbl[21] = '{4'h6, 1'b0, 4'h4, 2'd2, 8'h00};
        tbl[22] = '{4'h6, 1'b0, 4'h4, 2'd2, 8'h00};
        tbl[23] = '{4'h2, 1'b0, 4'h0, 2'd0, 8'h00};
        tbl[24] = '{4'h6, 1'b0, 4'h2, 2'd1, 8'hA5};
        tbl[25] = '{4'h6, 1'b1, 4'h0, 2'd0, 8'h00};
        tbl[26] = '{4'h9, 1'b0, 4'h8, 2'd3, 8'h00};
        tbl[27] = '{4'h0, 1'b0, 4'h0, 2'd0, 8'h00};
        tbl[28] = '{4'h1, 1'b0, 4'h1, 2'd0, 8'h00};
        tbl[29] = '{4'h1, 1'b1, 4'h0, 2'd0, 8'h00};

        reset      = 1'b1;
        in_ep_req  = '0;
        pe_in_done = 1'b0;
        in_ep_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 30; i++) begin
            cycle(tbl[i].req, tbl[i].done, 32'h0000_A500);
            chk($sformatf("vec%0d_grant", i), 32'(in_ep_grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d_owner", i), 32'(arb_owner), 32'(tbl[i].own));
            chk($sformatf("vec%0d_data", i), 32'(arb_in_ep_data), 32'(tbl[i].d));
        end

        // Async reset while EP2 holds the grant.
        cycle(4'h0, 1'b0, 32'h005C_0000);
        cycle(4'h4, 1'b0, 32'h005C_0000);
        chk("pre_rst_grant", 32'(in_ep_grant), 32'h4);
        chk("pre_rst_data", 32'(arb_in_ep_data), 32'h5C);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_grant", 32'(in_ep_grant), 32'h0);
        chk("rst_async_valid", 32'(arb_valid), 32'h0);
        chk("rst_async_data", 32'(arb_in_ep_data), 32'h0);
        #2;
        reset = 1'b0;
        m_owner = -1; m_ptr = 0; m_age = 0; m_to = 1'b0;
        cycle(4'h4, 1'b0, 32'h005C_0000);
        chk("post_rst_grant", 32'(in_ep_grant), 32'h4);
        cycle(4'h4, 1'b1, 32'h005C_0000);

        // Long hold with no done: watchdog fires only when enabled.
        for (int i = 0; i < 2 * TO; i++) cycle(4'h3, 1'b0, 32'h1122_3344);
        cycle(4'h0, 1'b0, 32'h1122_3344);

        r   = '0;
        dat = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            dat = $urandom;
            cycle(r, ($urandom_range(0, 5) == 0), dat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
